fft_result_serializer: RTL and testbench
========================================

FFT_RESULT_SERIALIZER -- requirements
Module: fft_result_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default `instWidth, width of each real/imag word.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports in_d1_real..in_d8_real, in_d1_imag..in_d8_imag  input  DATA_W each  signed parallel stage results; word k is frame index k-1.
REQ-005 SHALL have port in_ready  input  1  frame strobe from the butterfly stage (`funEnable = frame present this cycle).
REQ-006 SHALL have ports out_real, out_imag  output  DATA_W  serial result sample.
REQ-007 SHALL have ports out_valid  output 1, out_ready  input 1, out_index  output 3 (sample index 0..7), out_last  output 1 (index 7).
REQ-008 SHALL have ports busy  output 1 (active or pending frame held) and overflow  output 1 (sticky frame-drop flag).
REQ-009 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-010 SHALL hold two 8-sample complex frame buffers: ACTIVE (being streamed) and PENDING (one frame deep).
REQ-011 SHALL implement FSM states IDLE and STREAM; out_valid = 1 exactly in STREAM.
REQ-012 IDLE + in_ready: SHALL capture all 16 words into ACTIVE, set index 0, enter STREAM next cycle; first out_valid one cycle after in_ready.
REQ-013 STREAM: out_real/out_imag/out_index SHALL present ACTIVE[index] and stay stable while out_valid && !out_ready.
REQ-014 Beat transfers on out_valid && out_ready; index SHALL increment by 1 per beat; out_last = (index == 7).
REQ-015 Last beat with PENDING full: SHALL promote PENDING to ACTIVE, index 0, stay in STREAM with no bubble cycle.
REQ-016 Last beat with PENDING empty: SHALL return to IDLE, unless in_ready in same cycle, in which case the new frame loads directly into ACTIVE and STREAM continues without bubble.
REQ-017 in_ready during STREAM, not on last beat, PENDING empty: SHALL capture into PENDING.
REQ-018 in_ready during STREAM, PENDING full, not on last beat: SHALL drop the new frame, keep PENDING unchanged, set overflow.
REQ-019 in_ready on last beat with PENDING full: PENDING SHALL promote and new frame SHALL fill PENDING; no drop, overflow unchanged.
REQ-020 overflow SHALL stay set until ovf_clr or rst; ovf_clr and a new drop in the same cycle SHALL leave overflow set.
REQ-021 busy SHALL equal (state == STREAM) || PENDING full.
REQ-022 No arithmetic other than REQ-027; words SHALL pass bit-exact otherwise.

Reset
REQ-023 rst SHALL asynchronously force: state IDLE, index 0, PENDING empty, out_valid 0, out_last 0, busy 0, overflow 0, out_real 0, out_imag 0, out_index 0.
REQ-024 rst asserted mid-frame SHALL discard ACTIVE and PENDING; no beat is emitted until a new in_ready after rst deasserts.
REQ-025 in_ready coincident with rst SHALL be ignored.

Configuration
REQ-026 Macro FFT_SER_SCALE_EN SHALL select output scaling.
REQ-027 With FFT_SER_SCALE_EN defined: out_real/out_imag SHALL be the stored word arithmetic-shifted right by 3 (sign-extended, floor toward negative infinity), giving 1/8 IFFT normalisation; storage remains full-width.
REQ-028 Without FFT_SER_SCALE_EN: outputs SHALL be the stored words unmodified.

Verification
REQ-029 Single frame, in_d1..d8_real = 1..8, imag = -1..-8, out_ready held 1 -> beats on 8 consecutive cycles starting 1 cycle after in_ready, index 0..7, out_last only on beat 7, then IDLE, busy 0.
REQ-030 Backpressure: out_ready toggled 1,0,0,1,... -> every sample appears exactly once in order, values stable across stall cycles.
REQ-031 Three frames A,B,C with in_ready on cycles 0,2,4, out_ready 1 -> A then B streamed back-to-back (16 beats, no gap), C dropped, overflow = 1; ovf_clr pulse -> overflow 0.
REQ-032 Frame B in_ready exactly on A's last beat, PENDING empty -> B index 0 on the next cycle, no bubble, overflow 0.
REQ-033 rst pulsed after beat 3 of a frame with PENDING full -> out_valid 0 immediately, busy 0, no further beats until new in_ready.
REQ-034 With FFT_SER_SCALE_EN, input real = -9, imag = 17 -> out_real = -2, out_imag = 2; without macro -> -9, 17.

Source files
------------

// File: rtl/fft_result_serializer.sv
// fft_result_serializer
//
// Converts one parallel 8-point complex FFT result frame into a serial stream
// using a valid/ready handshake. There are two frame buffers:
//   ACTIVE  - the frame being streamed, one sample per accepted beat
//   PENDING - one frame of look-ahead. A frame that arrives while ACTIVE is
//             still streaming waits here.
// If a frame arrives while PENDING is already full, that frame is dropped and
// the sticky overflow flag is set.
//
// Optional feature (compile-time macro):
//   FFT_SER_SCALE_EN - out_real/out_imag are the stored words arithmetic-shifted
//                      right by 3 (1/8 IFFT normalisation). Storage stays full
//                      width. When the macro is undefined, words pass through
//                      unmodified.
//
// Ports:
//   clk                          single clock, rising edge
//   rst                          asynchronous, active-high reset
//   in_d1_real..in_d8_real       signed real words, word k is frame index k-1
//   in_d1_imag..in_d8_imag       signed imaginary words
//   in_ready                     frame strobe from the butterfly stage (`funEnable)
//   out_real, out_imag           serial sample ACTIVE[index]
//   out_valid                    high exactly while streaming
//   out_ready                    downstream accepts the current beat
//   out_index                    sample index 0..7
//   out_last                     current beat is index 7
//   busy                         streaming, or a frame is held in PENDING
//   overflow                     sticky flag set when a frame is dropped
//   ovf_clr                      synchronous clear of overflow

`ifndef instWidth
`define instWidth 16
`endif

module fft_result_serializer #(
    parameter int unsigned DATA_W = `instWidth
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic signed [DATA_W-1:0] in_d1_real,
    input  logic signed [DATA_W-1:0] in_d2_real,
    input  logic signed [DATA_W-1:0] in_d3_real,
    input  logic signed [DATA_W-1:0] in_d4_real,
    input  logic signed [DATA_W-1:0] in_d5_real,
    input  logic signed [DATA_W-1:0] in_d6_real,
    input  logic signed [DATA_W-1:0] in_d7_real,
    input  logic signed [DATA_W-1:0] in_d8_real,
    input  logic signed [DATA_W-1:0] in_d1_imag,
    input  logic signed [DATA_W-1:0] in_d2_imag,
    input  logic signed [DATA_W-1:0] in_d3_imag,
    input  logic signed [DATA_W-1:0] in_d4_imag,
    input  logic signed [DATA_W-1:0] in_d5_imag,
    input  logic signed [DATA_W-1:0] in_d6_imag,
    input  logic signed [DATA_W-1:0] in_d7_imag,
    input  logic signed [DATA_W-1:0] in_d8_imag,
    input  logic                     in_ready,

    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_index,
    output logic                     out_last,

    output logic                     busy,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } state_e;

    state_e                   state_q;
    logic [2:0]               idx_q;
    logic                     pnd_full_q;
    logic                     overflow_q;

    logic signed [DATA_W-1:0] act_re_q [8];
    logic signed [DATA_W-1:0] act_im_q [8];
    logic signed [DATA_W-1:0] pnd_re_q [8];
    logic signed [DATA_W-1:0] pnd_im_q [8];

    // Input frame gathered into arrays so that a whole frame can be copied in one assignment.
    logic signed [DATA_W-1:0] in_re [8];
    logic signed [DATA_W-1:0] in_im [8];

    logic streaming;
    logic beat;
    logic last_beat;
    logic drop;

    always_comb begin
        in_re[0] = in_d1_real;
        in_re[1] = in_d2_real;
        in_re[2] = in_d3_real;
        in_re[3] = in_d4_real;
        in_re[4] = in_d5_real;
        in_re[5] = in_d6_real;
        in_re[6] = in_d7_real;
        in_re[7] = in_d8_real;
        in_im[0] = in_d1_imag;
        in_im[1] = in_d2_imag;
        in_im[2] = in_d3_imag;
        in_im[3] = in_d4_imag;
        in_im[4] = in_d5_imag;
        in_im[5] = in_d6_imag;
        in_im[6] = in_d7_imag;
        in_im[7] = in_d8_imag;
    end

    always_comb begin
        streaming = (state_q == StStream);
        beat      = streaming && out_ready;
        last_beat = beat && (idx_q == 3'd7);
        // On the last beat, PENDING is emptied by promotion, so a new frame always has room.
        drop      = streaming && in_ready && !last_beat && pnd_full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            pnd_full_q <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                act_re_q[i] <= '0;
                act_im_q[i] <= '0;
                pnd_re_q[i] <= '0;
                pnd_im_q[i] <= '0;
            end
        end else begin
            // A drop in the same cycle as ovf_clr takes priority, so no event is lost.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (in_ready) begin
                        act_re_q <= in_re;
                        act_im_q <= in_im;
                        idx_q    <= 3'd0;
                        state_q  <= StStream;
                    end
                end

                StStream: begin
                    if (last_beat) begin
                        idx_q <= 3'd0;
                        if (pnd_full_q) begin
                            // Promote PENDING. A frame arriving now refills PENDING.
                            act_re_q <= pnd_re_q;
                            act_im_q <= pnd_im_q;
                            if (in_ready) begin
                                pnd_re_q <= in_re;
                                pnd_im_q <= in_im;
                            end else begin
                                pnd_full_q <= 1'b0;
                            end
                        end else if (in_ready) begin
                            // A new frame goes directly into ACTIVE, so there is no bubble cycle.
                            act_re_q <= in_re;
                            act_im_q <= in_im;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        if (beat) begin
                            idx_q <= idx_q + 3'd1;
                        end
                        if (in_ready && !pnd_full_q) begin
                            pnd_re_q   <= in_re;
                            pnd_im_q   <= in_im;
                            pnd_full_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
`ifdef FFT_SER_SCALE_EN
        // Arithmetic shift gives floor(x / 8) for both signs.
        out_real = act_re_q[idx_q] >>> 3;
        out_imag = act_im_q[idx_q] >>> 3;
`else
        out_real = act_re_q[idx_q];
        out_imag = act_im_q[idx_q];
`endif
        out_valid = streaming;
        out_index = idx_q;
        out_last  = streaming && (idx_q == 3'd7);
        busy      = streaming || pnd_full_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_fft_result_serializer.sv
// Testbench for fft_result_serializer.
// Expected samples are queued when a frame is driven. A forked monitor compares
// every valid output cycle against the head of the queue and pops it on each beat.

module tb_fft_result_serializer;

    localparam int W = 16;

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        int                  idx;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] in_re [8];
    logic signed [W-1:0] in_im [8];
    logic                in_ready;
    logic signed [W-1:0] out_real;
    logic signed [W-1:0] out_imag;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_index;
    logic                out_last;
    logic                busy;
    logic                overflow;
    logic                ovf_clr;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   beat_cnt = 0;
    int   beat_cyc [int];

    fft_result_serializer #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_d1_real(in_re[0]),
        .in_d2_real(in_re[1]),
        .in_d3_real(in_re[2]),
        .in_d4_real(in_re[3]),
        .in_d5_real(in_re[4]),
        .in_d6_real(in_re[5]),
        .in_d7_real(in_re[6]),
        .in_d8_real(in_re[7]),
        .in_d1_imag(in_im[0]),
        .in_d2_imag(in_im[1]),
        .in_d3_imag(in_im[2]),
        .in_d4_imag(in_im[3]),
        .in_d5_imag(in_im[4]),
        .in_d6_imag(in_im[5]),
        .in_d7_imag(in_im[6]),
        .in_d8_imag(in_im[7]),
        .in_ready  (in_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] v);
`ifdef FFT_SER_SCALE_EN
        return v >>> 3;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the current input frame as expected output if it should be accepted.
    // Then pulse in_ready for one cycle.
    task automatic launch(input bit accept);
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back('{re: scale(in_re[i]), im: scale(in_im[i]), idx: i});
            end
        end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
    endtask

    task automatic send_random(input bit accept);
        for (int i = 0; i < 8; i++) begin
            in_re[i] = W'($urandom);
            in_im[i] = W'($urandom);
        end
        launch(accept);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() == 0) ok = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: out_valid=1 index=%0d real=%0d, no beat expected",
                             out_index, out_real);
                end else begin
                    e = exp_q[0];
                    if (out_real !== e.re || out_imag !== e.im || out_index !== 3'(e.idx) ||
                        out_last !== 1'(e.idx == 7)) begin
                        errors++;
                        $display("FAIL beat: got re=%0d im=%0d idx=%0d last=%0b, want re=%0d im=%0d idx=%0d last=%0b",
                                 out_real, out_imag, out_index, out_last,
                                 e.re, e.im, e.idx, (e.idx == 7));
                    end
                end
                if (out_ready === 1'b1) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    beat_cyc[beat_cnt] = cyc;
                    beat_cnt++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_re[i] = W'(i + 3);
            in_im[i] = W'(i + 5);
        end
        in_ready = 1'b1;  // must be ignored while rst is high
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        checks++; if (out_real !== '0) begin errors++; $display("FAIL rst_out_real: got %0d want 0", out_real); end
        checks++; if (out_imag !== '0) begin errors++; $display("FAIL rst_out_imag: got %0d want 0", out_imag); end
        checks++; if (out_index !== 3'd0) begin errors++; $display("FAIL rst_out_index: got %0d want 0", out_index); end
        in_ready = 1'b0;
        rst = 1'b0;
        repeat (5) tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_in_ready_ignored: got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_single();
        int n0, t0; bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_re[i] = W'(i + 1);
            in_im[i] = W'(-(i + 1));
        end
        n0 = beat_cnt; t0 = cyc;
        launch(1'b1);
        wait_drain(40, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL single_drain: %0d samples left want 0", exp_q.size()); end
        checks++; if (beat_cnt - n0 != 8) begin errors++; $display("FAIL single_beats: got %0d want 8", beat_cnt - n0); end
        if (beat_cnt - n0 == 8) begin
            checks++; if (beat_cyc[n0] != t0 + 1) begin
                errors++; $display("FAIL single_latency: first beat cycle %0d want %0d", beat_cyc[n0], t0 + 1);
            end
            checks++; if (beat_cyc[n0 + 7] - beat_cyc[n0] != 7) begin
                errors++; $display("FAIL single_span: got %0d want 7", beat_cyc[n0 + 7] - beat_cyc[n0]);
            end
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int n0; bit ok;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        n0 = beat_cnt;
        send_random(1'b1);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            out_ready = pat[k % 4];
            tick();
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain: %0d samples left want 0", exp_q.size()); end
        checks++; if (beat_cnt - n0 != 8) begin errors++; $display("FAIL bp_beats: got %0d want 8", beat_cnt - n0); end
        if (beat_cnt - n0 == 8) begin
            checks++; if (beat_cyc[n0 + 7] - beat_cyc[n0] != 15) begin
                errors++; $display("FAIL bp_span: got %0d want 15", beat_cyc[n0 + 7] - beat_cyc[n0]);
            end
        end
    endtask

    task automatic test_overflow();
        int n0, t0; bit ok;
        out_ready = 1'b1;
        n0 = beat_cnt; t0 = cyc;
        send_random(1'b1); tick();
        send_random(1'b1); tick();
        send_random(1'b0);
        checks++; if (busy !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_after_drop: got busy=%b overflow=%b want 1 1", busy, overflow);
        end
        wait_drain(60, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain: %0d samples left want 0", exp_q.size()); end
        checks++; if (beat_cnt - n0 != 16) begin errors++; $display("FAIL ovf_beats: got %0d want 16", beat_cnt - n0); end
        if (beat_cnt - n0 == 16) begin
            checks++; if (beat_cyc[n0] != t0 + 1 || beat_cyc[n0 + 15] != t0 + 16) begin
                errors++; $display("FAIL ovf_timing: first %0d last %0d want %0d %0d",
                                   beat_cyc[n0], beat_cyc[n0 + 15], t0 + 1, t0 + 16);
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end

        // A clear in the same cycle as a drop must leave the flag set.
        send_random(1'b1); tick();
        send_random(1'b1); tick();
        ovf_clr = 1'b1;
        send_random(1'b0);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_drop: got %b want 1", overflow); end
        wait_drain(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain2: %0d samples left want 0", exp_q.size()); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        tick();
    endtask

    task automatic test_last_beat();
        int n0; bit ok;
        out_ready = 1'b1;
        // A new frame arrives exactly on A's last beat while PENDING is empty.
        n0 = beat_cnt;
        send_random(1'b1);
        repeat (7) tick();
        send_random(1'b1);
        wait_drain(60, ok);
        tick();
        checks++; if (!ok || beat_cnt - n0 != 16) begin
            errors++; $display("FAIL lastbeat_beats: got %0d want 16", beat_cnt - n0);
        end else begin
            checks++; if (beat_cyc[n0 + 15] - beat_cyc[n0] != 15) begin
                errors++; $display("FAIL lastbeat_bubble: span %0d want 15", beat_cyc[n0 + 15] - beat_cyc[n0]);
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL lastbeat_ovf: got %b want 0", overflow); end

        // A new frame arrives on the last beat while PENDING is full: promote and refill, with no drop.
        n0 = beat_cnt;
        send_random(1'b1); tick();
        send_random(1'b1);
        repeat (5) tick();
        send_random(1'b1);
        wait_drain(80, ok);
        tick();
        checks++; if (!ok || beat_cnt - n0 != 24) begin
            errors++; $display("FAIL refill_beats: got %0d want 24", beat_cnt - n0);
        end else begin
            checks++; if (beat_cyc[n0 + 23] - beat_cyc[n0] != 23) begin
                errors++; $display("FAIL refill_bubble: span %0d want 23", beat_cyc[n0 + 23] - beat_cyc[n0]);
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL refill_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int n1; bit ok;
        out_ready = 1'b1;
        send_random(1'b1); tick();
        send_random(1'b1);   // PENDING now full
        tick(); tick();      // beats 0..3 done
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 3'd0) begin
            errors++; $display("FAIL midrst_async: got valid=%b busy=%b idx=%0d want 0 0 0",
                               out_valid, busy, out_index);
        end
        exp_q.delete();
        n1 = beat_cnt;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        checks++; if (beat_cnt != n1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet: got %0d beats valid=%b want 0 beats valid=0",
                               beat_cnt - n1, out_valid);
        end
        send_random(1'b1);
        wait_drain(40, ok);
        tick();
        checks++; if (!ok || beat_cnt - n1 != 8) begin
            errors++; $display("FAIL midrst_restart: got %0d beats want 8", beat_cnt - n1);
        end
    endtask

    task automatic test_scale();
        bit ok;
        logic signed [W-1:0] want_re, want_im;
`ifdef FFT_SER_SCALE_EN
        want_re = -16'sd2; want_im = 16'sd2;
`else
        want_re = -16'sd9; want_im = 16'sd17;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_re[i] = W'($urandom);
            in_im[i] = W'($urandom);
        end
        in_re[0] = -16'sd9;
        in_im[0] = 16'sd17;
        launch(1'b1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_real !== want_re || out_imag !== want_im) begin
            errors++; $display("FAIL scale: got valid=%b re=%0d im=%0d want 1 %0d %0d",
                               out_valid, out_real, out_imag, want_re, want_im);
        end
        wait_drain(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL scale_drain: %0d samples left want 0", exp_q.size()); end
        tick();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_last_beat();
        test_reset_mid();
        test_scale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
